// File: rtl/b1_dec_seq.sv
// Sequenced 4-to-16 one-hot decoder: holds each accepted code for HOLD cycles, then one idle gap cycle.
// Optional even-parity check on the accepted code when B1_DEC_PARITY_EN is defined.
module b1_dec_seq #(
    parameter int HOLD = 4,
    parameter int CW   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  binary_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        enable,
    output logic [15:0] dec_out,
    output logic        out_valid,
    output logic        busy,
    output logic        done
`ifdef B1_DEC_PARITY_EN
    ,
    input  logic        parity_in,
    output logic        par_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   dec_n;
    logic          ov_n;
    logic          accept;
    logic          code_ok;
    logic          perr_q, perr_n;

    assign in_ready = (state == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_GAP);

`ifdef B1_DEC_PARITY_EN
    assign code_ok  = ~^{binary_in, parity_in};
    assign par_err  = perr_q;
`else
    assign code_ok  = 1'b1;
`endif

    // A rejected code is remembered for exactly the GAP cycle that follows it.
    assign perr_n = accept && !code_ok;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dec_n   = dec_out;
        ov_n    = out_valid;
        case (state)
            S_IDLE: begin
                dec_n = 16'h0000;
                ov_n  = 1'b0;
                if (accept) begin
                    if (enable && code_ok) begin
                        state_n = S_HOLD;
                        dec_n   = 16'h0001 << binary_in;
                        ov_n    = 1'b1;
                        cnt_n   = CNT_LOAD;
                    end else begin
                        state_n = S_GAP;
                    end
                end
            end
            S_HOLD: begin
                // Dropping enable aborts the hold early but still passes through GAP.
                if (!enable || cnt == '0) begin
                    state_n = S_GAP;
                    dec_n   = 16'h0000;
                    ov_n    = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_GAP: begin
                state_n = S_IDLE;
                dec_n   = 16'h0000;
                ov_n    = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                dec_n   = 16'h0000;
                ov_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            dec_out   <= 16'h0000;
            out_valid <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dec_out   <= dec_n;
            out_valid <= ov_n;
            perr_q    <= perr_n;
        end
    end

endmodule

// File: tb/tb_b1_dec_seq.sv
// Self-checking bench for b1_dec_seq: directed scenarios plus randomized traffic against a timeline model.
module tb_b1_dec_seq;

    localparam int HOLD = 4;
    localparam int CW   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  binary_in = 4'h0;
    logic        in_valid = 1'b0;
    logic        enable = 1'b0;
    logic        in_ready;
    logic [15:0] dec_out;
    logic        out_valid;
    logic        busy;
    logic        done;
`ifdef B1_DEC_PARITY_EN
    logic        parity_in = 1'b0;
    logic        par_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    b1_dec_seq #(.HOLD(HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .binary_in (binary_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enable    (enable),
        .dec_out   (dec_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
`ifdef B1_DEC_PARITY_EN
        ,
        .parity_in (parity_in),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    // Timeline model: each accepted code books absolute cycle windows for its pulse, gap and return to idle.
    longint cyc    = 0;
    longint live_s = -10;
    longint live_e = -10;
    longint gap_c  = -10;
    longint idle_c = 0;
    longint perr_c = -10;
    logic [3:0] m_code = 4'h0;

    function automatic logic model_par_ok();
`ifdef B1_DEC_PARITY_EN
        return (^{binary_in, parity_in}) == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            idle_c = cyc;
            live_s = -10;
            live_e = -10;
            gap_c  = -10;
            perr_c = -10;
        end else if (cyc - 1 >= idle_c && in_valid) begin
            m_code = binary_in;
            if (enable && model_par_ok()) begin
                live_s = cyc;
                live_e = cyc + HOLD - 1;
                gap_c  = cyc + HOLD;
                idle_c = cyc + HOLD + 1;
            end else begin
                gap_c  = cyc;
                idle_c = cyc + 1;
                if (!model_par_ok()) perr_c = cyc;
            end
        end else if (cyc - 1 >= live_s && cyc - 1 <= live_e && !enable) begin
            live_e = cyc - 1;
            gap_c  = cyc;
            idle_c = cyc + 1;
        end
    end

    // {dec_out, out_valid, done, busy, in_ready, par_err}
    function automatic logic [20:0] exp_vec();
        logic ov, bz;
        logic [15:0] d;
        ov = (cyc >= live_s) && (cyc <= live_e);
        d  = ov ? (16'h0001 << m_code) : 16'h0000;
        bz = (cyc < idle_c);
        return {d, ov, (cyc == gap_c), bz, (!bz && !rst), (cyc == perr_c)};
    endfunction

    function automatic logic [20:0] obs_vec();
`ifdef B1_DEC_PARITY_EN
        return {dec_out, out_valid, done, busy, in_ready, par_err};
`else
        return {dec_out, out_valid, done, busy, in_ready, 1'b0};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; enable = 1'b1; binary_in = 4'h5;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (dec_out !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got dec=%h ov=%b rdy=%b busy=%b done=%b want all zero",
                         cyc, dec_out, out_valid, in_ready, busy, done);
            end
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_single();
        binary_in = 4'hA; in_valid = 1'b1; enable = 1'b1;
        step();
        in_valid = 1'b0; binary_in = 4'h0;
        for (int i = 0; i < HOLD; i++) begin
            n_checks++;
            if (dec_out !== 16'h0400 || out_valid !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_hold[%0d] got dec=%h ov=%b done=%b want 0400/1/0", i, dec_out, out_valid, done);
            end
            step();
        end
        n_checks++;
        if (dec_out !== 16'h0000 || done !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gap got dec=%h done=%b rdy=%b want 0000/1/0", dec_out, done, in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got rdy=%b done=%b busy=%b want 1/0/0", in_ready, done, busy);
        end
    endtask

    task automatic test_back_to_back();
        binary_in = 4'h0; in_valid = 1'b1; enable = 1'b1;
        step();
        binary_in = 4'hF;
        for (int i = 0; i < 2 * (HOLD + 2); i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec() || $countones(dec_out) > 1) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < HOLD + 2; i++) step();
        n_checks++;
        if (in_ready !== 1'b1 || m_code !== 4'hF) begin
            n_fail++;
            $display("FAIL back_to_back_end got rdy=%b code=%h want 1/F", in_ready, m_code);
        end
    endtask

    task automatic test_abort();
        binary_in = 4'h3; in_valid = 1'b1; enable = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (dec_out !== 16'h0008) begin
            n_fail++;
            $display("FAIL abort_first got dec=%h want 0008", dec_out);
        end
        step();
        enable = 1'b0;
        step();
        n_checks++;
        if (dec_out !== 16'h0000 || out_valid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_gap got dec=%h ov=%b done=%b want 0000/0/1", dec_out, out_valid, done);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle got rdy=%b busy=%b done=%b want 1/0/0", in_ready, busy, done);
        end
    endtask

    task automatic test_disabled_then_reset();
        binary_in = 4'h9; in_valid = 1'b1; enable = 1'b0;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (dec_out !== 16'h0000 || out_valid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL disabled_gap got dec=%h ov=%b done=%b want 0000/0/1", dec_out, out_valid, done);
        end
        step();
        binary_in = 4'h6; in_valid = 1'b1; enable = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (dec_out !== 16'h0040) begin
            n_fail++;
            $display("FAIL disabled_next got dec=%h want 0040", dec_out);
        end
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (dec_out !== 16'h0000 || out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold got dec=%h ov=%b done=%b busy=%b want all zero", dec_out, out_valid, done, busy);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_hold_after got done=%b rdy=%b want 0/1", done, in_ready);
        end
    endtask

`ifdef B1_DEC_PARITY_EN
    task automatic test_parity();
        binary_in = 4'h7; parity_in = 1'b0; in_valid = 1'b1; enable = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (dec_out !== 16'h0000 || par_err !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad got dec=%h perr=%b done=%b want 0000/1/1", dec_out, par_err, done);
        end
        step();
        parity_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            n_checks++;
            if (dec_out !== 16'h0080 || par_err !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_good[%0d] got dec=%h perr=%b want 0080/0", i, dec_out, par_err);
            end
            step();
        end
        step();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            binary_in = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 59) == 0);
`ifdef B1_DEC_PARITY_EN
            parity_in = ($urandom_range(0, 4) == 0) ? ~^binary_in : ^binary_in;
`endif
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_disabled_then_reset();
`ifdef B1_DEC_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
